// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_port_arbiter.
// slave is the arbiter's view; master is the view of the requesters and RAM combined.
interface ram_port_arbiter_if #(
   parameter int unsigned N_REQ  = 2,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                               boot_lock;
   logic [N_REQ-1:0]                   req;
   logic [N_REQ-1:0][1:0]              req_op;
   logic [N_REQ-1:0][ADDR_W-1:0]       req_addr;
   logic [N_REQ-1:0][1:0]              req_size;
   logic [N_REQ-1:0][DATA_W-1:0]       req_wdata;
   logic [N_REQ-1:0]                   gnt;
   logic [N_REQ-1:0]                   rvalid;
   logic [DATA_W-1:0]                  rdata;
   logic [1:0]                         ram_op;
   logic [ADDR_W-1:0]                  ram_addr;
   logic [1:0]                         ram_size;
   logic [DATA_W-1:0]                  ram_data_in;
   logic [DATA_W-1:0]                  ram_data_out;

   modport slave (
      input  boot_lock, req, req_op, req_addr, req_size, req_wdata, ram_data_out,
      output gnt, rvalid, rdata, ram_op, ram_addr, ram_size, ram_data_in
   );

   modport master (
      output boot_lock, req, req_op, req_addr, req_size, req_wdata, ram_data_out,
      input  gnt, rvalid, rdata, ram_op, ram_addr, ram_size, ram_data_in
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one registered RAM port among N_REQ requesters,
// with a fixed-latency return pipe that routes load data back to its issuer.
module ram_port_arbiter #(
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned RAM_LAT = 1,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
) (
   input logic               clk,
   input logic               rst,
   ram_port_arbiter_if.slave bus
);
   localparam logic [1:0] RAM_NOP  = 2'd0;
   localparam logic [1:0] RAM_LOAD = 2'd1;
   localparam int unsigned IDW     = $clog2(N_REQ);

   logic [N_REQ-1:0]              gnt_q, gnt_d, elig;
   logic [IDW-1:0]                prio_q, prio_d, win, issue_id_q;
   logic                          win_valid;
   logic [1:0]                    ram_op_q, ram_op_d, ram_size_q, ram_size_d;
   logic [ADDR_W-1:0]             ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]             ram_din_q, ram_din_d, rdata_q;
   logic [N_REQ-1:0]              rvalid_q, rvalid_d;
   logic [RAM_LAT-1:0]            pipe_vld_q;
   logic [RAM_LAT-1:0][IDW-1:0]   pipe_id_q;

   function automatic logic [IDW-1:0] wrap_idx(logic [IDW-1:0] base, int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      return IDW'(s % N_REQ);
   endfunction

   // A request still held in its grant cycle is masked so it is not granted twice.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = bus.req[i] && (bus.req_op[i] != RAM_NOP) && !gnt_q[i] &&
                   (!bus.boot_lock || (i == 0));
      end
   end

   always_comb begin
      logic [IDW-1:0] cand;
      win       = '0;
      win_valid = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = wrap_idx(prio_q, k);
         if (!win_valid && elig[cand]) begin
            win_valid = 1'b1;
            win       = cand;
         end
      end
   end

   always_comb begin
      gnt_d      = '0;
      prio_d     = prio_q;
      ram_op_d   = RAM_NOP;
      ram_addr_d = ram_addr_q;
      ram_size_d = ram_size_q;
      ram_din_d  = ram_din_q;
      if (win_valid) begin
         gnt_d[win] = 1'b1;
         prio_d     = wrap_idx(win, 1);
         ram_op_d   = bus.req_op[win];
         ram_addr_d = bus.req_addr[win];
         ram_size_d = bus.req_size[win];
         ram_din_d  = bus.req_wdata[win];
      end
   end

   always_comb begin
      rvalid_d = '0;
      if (pipe_vld_q[RAM_LAT-1]) rvalid_d[pipe_id_q[RAM_LAT-1]] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_q      <= '0;
         prio_q     <= '0;
         issue_id_q <= '0;
         ram_op_q   <= RAM_NOP;
         ram_addr_q <= '0;
         ram_size_q <= '0;
         ram_din_q  <= '0;
      end else begin
         gnt_q      <= gnt_d;
         prio_q     <= prio_d;
         issue_id_q <= win;
         ram_op_q   <= ram_op_d;
         ram_addr_q <= ram_addr_d;
         ram_size_q <= ram_size_d;
         ram_din_q  <= ram_din_d;
      end
   end

   // Pipe is fed from the registered op, so its tail lines up with ram_data_out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_vld_q <= '0;
         pipe_id_q  <= '0;
         rvalid_q   <= '0;
         rdata_q    <= '0;
      end else begin
         pipe_vld_q[0] <= (ram_op_q == RAM_LOAD);
         pipe_id_q[0]  <= issue_id_q;
         for (int s = 1; s < RAM_LAT; s++) begin
            pipe_vld_q[s] <= pipe_vld_q[s-1];
            pipe_id_q[s]  <= pipe_id_q[s-1];
         end
         rvalid_q <= rvalid_d;
         if (pipe_vld_q[RAM_LAT-1]) rdata_q <= bus.ram_data_out;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.rvalid      = rvalid_q;
   assign bus.rdata       = rdata_q;
   assign bus.ram_op      = ram_op_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_size    = ram_size_q;
   assign bus.ram_data_in = ram_din_q;
endmodule
